imem_if: RTL and testbench

IMEM_IF -- requirements
Module: imem_if

---
 rtl/imem_if.sv | 194 +++++++++++++++++++
 tb/tb_imem_if.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_if.sv
// Instruction-memory fetch interface: one outstanding read, 2-entry in-order
// decode buffer, flush with discard of the in-flight response.
module imem_if #(
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter logic [31:0] RESET_PC_D = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_f,
    input  logic        flush,
    output logic        fetch_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_d,
    output logic [31:0] PC_d,
    input  logic        decode_ready
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_FLUSHED = 2'd2
    } state_e;

    state_e      state_r;
    logic [31:0] pending_pc_r;
    logic [1:0]  count_r;
    logic [31:0] e0_instr_r;
    logic [31:0] e0_pc_r;
    logic [31:0] e1_instr_r;
    logic [31:0] e1_pc_r;
    logic        instr_valid_r;
    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;

    logic [1:0]  count_next_s;
    logic [31:0] e0_instr_next_s;
    logic [31:0] e0_pc_next_s;
    logic [31:0] e1_instr_next_s;
    logic [31:0] e1_pc_next_s;
    logic        push_s;
    logic        pop_s;
    logic        req_s;
    logic        grant_s;

    // Push/pop qualification; reset and flush suppress both.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (rst || flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = (state_r == ST_BUSY) && mem_rvalid;
            pop_s  = (count_r != 2'd0) && decode_ready;
        end
    end

    // Next buffer contents and occupancy (entry 0 is the head).
    always_comb begin
        e0_instr_next_s = e0_instr_r;
        e0_pc_next_s    = e0_pc_r;
        e1_instr_next_s = e1_instr_r;
        e1_pc_next_s    = e1_pc_r;
        count_next_s    = count_r;
        if (rst || flush) begin
            count_next_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        e0_instr_next_s = mem_rdata;
                        e0_pc_next_s    = pending_pc_r;
                        count_next_s    = 2'd1;
                    end else if (count_r == 2'd1) begin
                        e1_instr_next_s = mem_rdata;
                        e1_pc_next_s    = pending_pc_r;
                        count_next_s    = 2'd2;
                    end else begin
                        count_next_s = count_r;
                    end
                end
                2'b01: begin
                    e0_instr_next_s = e1_instr_r;
                    e0_pc_next_s    = e1_pc_r;
                    count_next_s    = count_r - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy unchanged, order kept.
                    if (count_r == 2'd2) begin
                        e0_instr_next_s = e1_instr_r;
                        e0_pc_next_s    = e1_pc_r;
                        e1_instr_next_s = mem_rdata;
                        e1_pc_next_s    = pending_pc_r;
                    end else begin
                        e0_instr_next_s = mem_rdata;
                        e0_pc_next_s    = pending_pc_r;
                    end
                    count_next_s = count_r;
                end
                default: begin
                    count_next_s = count_r;
                end
            endcase
        end
    end

    // Request only when no response is owed (or it lands now) and space remains.
    always_comb begin
        req_s = 1'b0;
        if (rst) begin
            req_s = 1'b0;
        end else begin
            req_s = ((state_r == ST_IDLE) || mem_rvalid) && (count_next_s < 2'd2);
        end
    end

    assign grant_s     = req_s & mem_gnt;
    assign mem_req     = req_s;
    assign mem_addr    = PC_f;
    assign fetch_stall = ~grant_s;

    // Outstanding-request FSM and address of the pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pending_pc_r <= 32'h0000_0000;
        end else begin
            if (grant_s) begin
                pending_pc_r <= PC_f;
            end
            case (state_r)
                ST_IDLE: begin
                    state_r <= grant_s ? ST_BUSY : ST_IDLE;
                end
                ST_BUSY: begin
                    if (grant_s) begin
                        state_r <= ST_BUSY;
                    end else if (mem_rvalid) begin
                        state_r <= ST_IDLE;
                    end else if (flush) begin
                        state_r <= ST_FLUSHED;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_FLUSHED: begin
                    if (grant_s) begin
                        state_r <= ST_BUSY;
                    end else if (mem_rvalid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_FLUSHED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer storage and registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r       <= 2'd0;
            e0_instr_r    <= 32'h0000_0000;
            e0_pc_r       <= 32'h0000_0000;
            e1_instr_r    <= 32'h0000_0000;
            e1_pc_r       <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            instr_d_r     <= NOP_INSTR;
            pc_d_r        <= RESET_PC_D;
        end else begin
            count_r       <= count_next_s;
            e0_instr_r    <= e0_instr_next_s;
            e0_pc_r       <= e0_pc_next_s;
            e1_instr_r    <= e1_instr_next_s;
            e1_pc_r       <= e1_pc_next_s;
            instr_valid_r <= (count_next_s != 2'd0);
            instr_d_r     <= (count_next_s != 2'd0) ? e0_instr_next_s : NOP_INSTR;
            pc_d_r        <= (count_next_s != 2'd0) ? e0_pc_next_s : RESET_PC_D;
        end
    end

    assign instr_valid = instr_valid_r;
    assign instr_d     = instr_d_r;
    assign PC_d        = pc_d_r;

endmodule

// File: tb/tb_imem_if.sv
// Bench for imem_if: queue-based reference model checked every cycle, a
// latency-programmable memory, and directed scenarios with literal checks.
module tb_imem_if;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] PC_f;
    logic        flush;
    logic        fetch_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_d;
    logic [31:0] PC_d;
    logic        decode_ready;

    int          total = 0;
    int          bad = 0;

    int          lat;
    logic        last_grant;
    logic        mbusy;
    int          mcnt;
    logic [31:0] maddr;

    logic [63:0] q[$];
    logic        m_out;
    logic        m_drop;
    logic [31:0] m_pc;

    imem_if #(.NOP_INSTR(NOP), .RESET_PC_D(RPC)) dut (
        .clk(clk), .rst(rst), .PC_f(PC_f), .flush(flush),
        .fetch_stall(fetch_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_d(instr_d), .PC_d(PC_d),
        .decode_ready(decode_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory: answers each grant with ~address after 'lat' cycles; keeps its
    // pending request across a DUT reset like a real memory would.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mbusy      = 1'b0;
        mcnt       = 0;
        maddr      = 32'h0;
        last_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rvalid) mbusy = 1'b0;
            if (mem_req && mem_gnt) begin
                mbusy = 1'b1;
                mcnt  = lat;
                maddr = mem_addr;
            end
            last_grant = mem_req && mem_gnt;
            @(posedge clk);
            #1;
            if (mbusy) begin
                mcnt       = mcnt - 1;
                mem_rvalid = (mcnt == 0);
            end else begin
                mem_rvalid = 1'b0;
            end
            mem_rdata = mem_rvalid ? ~maddr : 32'h0;
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        logic        ev, rv, pu, po, ereq, egr;
        logic [31:0] ei, ep;
        int          ecount;
        q.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_pc   = 32'h0;
        forever begin
            @(negedge clk);
            ev = (q.size() > 0);
            ei = ev ? q[0][63:32] : NOP;
            ep = ev ? q[0][31:0] : RPC;
            chk("cyc_instr_valid", {31'd0, instr_valid}, {31'd0, ev});
            chk("cyc_instr_d", instr_d, ei);
            chk("cyc_PC_d", PC_d, ep);
            chk("cyc_mem_addr", mem_addr, PC_f);
            rv = 1'b0; pu = 1'b0; po = 1'b0; ereq = 1'b0;
            if (!rst) begin
                rv     = mem_rvalid && m_out;
                pu     = rv && !m_drop && !flush;
                po     = !flush && ev && decode_ready;
                ecount = flush ? 0 : q.size() + (pu ? 1 : 0) - (po ? 1 : 0);
                ereq   = (!m_out || mem_rvalid) && (ecount < 2);
            end
            egr = ereq && mem_gnt;
            chk("cyc_mem_req", {31'd0, mem_req}, {31'd0, ereq});
            chk("cyc_fetch_stall", {31'd0, fetch_stall}, {31'd0, !egr});
            if (rst) begin
                q.delete();
                m_out  = 1'b0;
                m_drop = 1'b0;
                m_pc   = 32'h0;
            end else begin
                if (flush) begin
                    q.delete();
                end else begin
                    if (po) void'(q.pop_front());
                    if (pu) q.push_back({mem_rdata, m_pc});
                end
                if (egr) begin
                    m_out  = 1'b1;
                    m_drop = 1'b0;
                    m_pc   = PC_f;
                end else if (rv) begin
                    m_out = 1'b0;
                end else if (flush && m_out) begin
                    m_drop = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (last_grant) PC_f = PC_f + 32'd4;
    endtask

    task automatic look();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want finish before limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; PC_f = 32'h8000_0000;
        mem_gnt = 1'b1; decode_ready = 1'b1; lat = 1;
        step(); look();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd1);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr_d", instr_d, 32'h0000_0013);
        chk("rst_PC_d", PC_d, 32'h0000_0000);

        // Back-to-back fetch with a 1-cycle memory.
        step(); rst = 1'b0; look();
        chk("c0_mem_req", {31'd0, mem_req}, 32'd1);
        chk("c0_mem_addr", mem_addr, 32'h8000_0000);
        step(); look();
        chk("c1_instr_valid", {31'd0, instr_valid}, 32'd0);
        step(); look();
        chk("c2_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("c2_PC_d", PC_d, 32'h8000_0000);
        chk("c2_instr_d", instr_d, 32'h7FFF_FFFF);
        step(); look();
        chk("c3_PC_d", PC_d, 32'h8000_0004);
        step(); step();

        // Decode stalls for 5 cycles: buffer fills, requests stop.
        step(); decode_ready = 1'b0; look();
        chk("c6_mem_req", {31'd0, mem_req}, 32'd0);
        repeat (4) step();
        look();
        chk("c10_mem_req", {31'd0, mem_req}, 32'd0);
        chk("c10_fetch_stall", {31'd0, fetch_stall}, 32'd1);
        chk("c10_PC_d", PC_d, 32'h8000_0010);
        chk("c10_mem_addr", mem_addr, 32'h8000_0018);
        step(); decode_ready = 1'b1; look();
        chk("c11_PC_d", PC_d, 32'h8000_0010);
        chk("c11_mem_req", {31'd0, mem_req}, 32'd1);
        step(); look();
        chk("c12_PC_d", PC_d, 32'h8000_0014);
        step(); look();
        chk("c13_PC_d", PC_d, 32'h8000_0018);

        // No grant for 3 cycles.
        step(); mem_gnt = 1'b0;
        step(); step(); look();
        chk("c16_fetch_stall", {31'd0, fetch_stall}, 32'd1);
        chk("c16_mem_req", {31'd0, mem_req}, 32'd1);
        chk("c16_mem_addr", mem_addr, 32'h8000_0024);
        chk("c16_instr_valid", {31'd0, instr_valid}, 32'd0);

        // Flush while a 3-cycle request is pending.
        step(); mem_gnt = 1'b1; lat = 3;
        step(); flush = 1'b1; PC_f = 32'h8000_0100; look();
        chk("c18_mem_req", {31'd0, mem_req}, 32'd0);
        step(); flush = 1'b0; look();
        chk("c19_mem_req", {31'd0, mem_req}, 32'd0);
        step(); look();
        chk("c20_mem_req", {31'd0, mem_req}, 32'd1);
        chk("c20_mem_addr", mem_addr, 32'h8000_0100);
        step(); lat = 1; look();
        chk("c21_instr_valid", {31'd0, instr_valid}, 32'd0);
        repeat (2) begin
            step(); look();
            chk("c22_23_instr_valid", {31'd0, instr_valid}, 32'd0);
        end
        step(); look();
        chk("c24_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("c24_PC_d", PC_d, 32'h8000_0100);
        chk("c24_instr_d", instr_d, 32'h7FFF_FEFF);

        // Fill to 2, then flush with a pop at count 2; flush-cycle grant kept.
        step(); decode_ready = 1'b0; look();
        chk("c25_mem_req", {31'd0, mem_req}, 32'd0);
        step(); flush = 1'b1; decode_ready = 1'b1; PC_f = 32'h8000_0200; look();
        chk("c26_PC_d", PC_d, 32'h8000_0104);
        chk("c26_mem_req", {31'd0, mem_req}, 32'd1);
        chk("c26_mem_addr", mem_addr, 32'h8000_0200);
        step(); flush = 1'b0; look();
        chk("c27_instr_valid", {31'd0, instr_valid}, 32'd0);

        // Flush coincident with a response and a pop.
        step(); flush = 1'b1; PC_f = 32'h8000_0300; look();
        chk("c28_PC_d", PC_d, 32'h8000_0200);
        chk("c28_mem_req", {31'd0, mem_req}, 32'd1);
        chk("c28_mem_addr", mem_addr, 32'h8000_0300);
        step(); flush = 1'b0; look();
        chk("c29_instr_valid", {31'd0, instr_valid}, 32'd0);
        step(); lat = 3; look();
        chk("c30_PC_d", PC_d, 32'h8000_0300);
        chk("c30_instr_d", instr_d, 32'h7FFF_FCFF);

        // Reset with a request outstanding; its response lands after release.
        step(); rst = 1'b1; mem_gnt = 1'b0; look();
        chk("c31_mem_req", {31'd0, mem_req}, 32'd0);
        chk("c31_fetch_stall", {31'd0, fetch_stall}, 32'd1);
        step(); look();
        chk("c32_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("c32_PC_d", PC_d, 32'h0000_0000);
        chk("c32_instr_d", instr_d, 32'h0000_0013);
        step(); rst = 1'b0; look();
        chk("c33_instr_valid", {31'd0, instr_valid}, 32'd0);
        step(); look();
        chk("c34_instr_valid", {31'd0, instr_valid}, 32'd0);
        step(); mem_gnt = 1'b1; lat = 1; look();
        chk("c35_mem_req", {31'd0, mem_req}, 32'd1);
        chk("c35_mem_addr", mem_addr, 32'h8000_030C);
        step(); look();
        chk("c36_instr_valid", {31'd0, instr_valid}, 32'd0);
        step(); look();
        chk("c37_PC_d", PC_d, 32'h8000_030C);
        repeat (3) step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
